// File: rtl/hs_packet_demux.sv
// hs_packet_demux: 1:N valid/ready/last packet router with one registered output stage.
// Define HS_PACKET_DEMUX_ERR_EN to drop out-of-range packets and count them (err_pulse/err_cnt).
module hs_packet_demux #(
   parameter int OUT_NUM = 8,
   parameter int DATA_WD = 8,
   parameter bit USE_LAST = 1'b1,
   localparam int DEST_WD = $clog2(OUT_NUM)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       valid_in,
   input  logic [DATA_WD-1:0]         payload_in,
   input  logic                       last_in,
   input  logic [DEST_WD-1:0]         dest_in,
   output logic                       ready_in,
   output logic [OUT_NUM-1:0]         valid_out,
   output logic [OUT_NUM*DATA_WD-1:0] payload_out,
   output logic [OUT_NUM-1:0]         last_out,
   input  logic [OUT_NUM-1:0]         ready_out
`ifdef HS_PACKET_DEMUX_ERR_EN
   ,
   output logic                       err_pulse,
   output logic [7:0]                 err_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, ROUTE, DRAIN} state_t;
   state_t state;
   logic stg_vld, stg_last, dest_ok, fire, drop, pkt_end;
   logic [DEST_WD-1:0] sel_r, route_r, dest_sel;
   logic [DATA_WD-1:0] stg_data;
   assign dest_ok = {1'b0, dest_in} < (DEST_WD + 1)'(OUT_NUM);
   assign dest_sel = (USE_LAST && state == ROUTE) ? route_r : dest_ok ? dest_in : '0;
`ifdef HS_PACKET_DEMUX_ERR_EN
   assign drop = state == DRAIN || (state == IDLE && !dest_ok);
   assign ready_in = rstn && (state == DRAIN || !stg_vld || ready_out[sel_r]);
`else
   assign drop = 1'b0;
   assign ready_in = rstn && (!stg_vld || ready_out[sel_r]);
`endif
   assign fire = valid_in && ready_in;
   assign pkt_end = last_in || !USE_LAST;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         stg_vld  <= 1'b0;
         stg_last <= 1'b0;
         stg_data <= '0;
         sel_r    <= '0;
         route_r  <= '0;
`ifdef HS_PACKET_DEMUX_ERR_EN
         err_pulse <= 1'b0;
         err_cnt   <= 8'd0;
`endif
      end else begin
         if (stg_vld && ready_out[sel_r]) stg_vld <= 1'b0;
         // a load in the same cycle as a drain overrides the clear above
         if (fire && !drop) begin
            stg_vld  <= 1'b1;
            sel_r    <= dest_sel;
            stg_data <= payload_in;
            stg_last <= last_in;
         end
`ifdef HS_PACKET_DEMUX_ERR_EN
         err_pulse <= 1'b0;
`endif
         if (fire) begin
            if (state == IDLE) route_r <= dest_sel;
`ifdef HS_PACKET_DEMUX_ERR_EN
            if (drop && pkt_end) begin
               err_pulse <= 1'b1;
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            state <= pkt_end ? IDLE : drop ? DRAIN : ROUTE;
`else
            state <= pkt_end ? IDLE : ROUTE;
`endif
         end
      end
   end
   always_comb begin
      valid_out = '0;
      last_out = '0;
      valid_out[sel_r] = stg_vld;
      last_out[sel_r] = stg_vld && stg_last;
      payload_out = {OUT_NUM{stg_data}};
   end
endmodule

// File: tb/tb_hs_packet_demux.sv
// tb_hs_packet_demux: directed checks of hs_packet_demux (8-port packet mode, 8-port per-beat mode, 6-port).
// Honours HS_PACKET_DEMUX_ERR_EN for the out-of-range expectations.
module tb_hs_packet_demux;
   logic clk = 1'b0;
   logic rstn, valid_in, last_in;
   logic [7:0] payload_in, ready_out;
   logic [2:0] dest_in;
   logic ready_in_a, ready_in_b, ready_in_c;
   logic [7:0] valid_out_a, last_out_a, valid_out_b, last_out_b;
   logic [5:0] valid_out_c, last_out_c;
   logic [63:0] payload_out_a, payload_out_b;
   logic [47:0] payload_out_c;
`ifdef HS_PACKET_DEMUX_ERR_EN
   logic ep_a, ep_b, ep_c;
   logic [7:0] ec_a, ec_b, ec_c;
`endif
   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   hs_packet_demux #(.OUT_NUM(8), .DATA_WD(8), .USE_LAST(1'b1)) u_a (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .dest_in(dest_in), .ready_in(ready_in_a), .valid_out(valid_out_a), .payload_out(payload_out_a),
      .last_out(last_out_a), .ready_out(ready_out)
`ifdef HS_PACKET_DEMUX_ERR_EN
      , .err_pulse(ep_a), .err_cnt(ec_a)
`endif
   );
   hs_packet_demux #(.OUT_NUM(8), .DATA_WD(8), .USE_LAST(1'b0)) u_b (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .dest_in(dest_in), .ready_in(ready_in_b), .valid_out(valid_out_b), .payload_out(payload_out_b),
      .last_out(last_out_b), .ready_out(ready_out)
`ifdef HS_PACKET_DEMUX_ERR_EN
      , .err_pulse(ep_b), .err_cnt(ec_b)
`endif
   );
   hs_packet_demux #(.OUT_NUM(6), .DATA_WD(8), .USE_LAST(1'b1)) u_c (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .dest_in(dest_in), .ready_in(ready_in_c), .valid_out(valid_out_c), .payload_out(payload_out_c),
      .last_out(last_out_c), .ready_out(ready_out[5:0])
`ifdef HS_PACKET_DEMUX_ERR_EN
      , .err_pulse(ep_c), .err_cnt(ec_c)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [7:0] p, input logic l, input logic [2:0] d);
      valid_in = v; payload_in = p; last_in = l; dest_in = d;
   endtask

   // inputs change 1 time unit after the rising edge; checks happen at the falling edge
   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; drv(0, 8'h00, 0, 3'd0); ready_out = 8'hFF;
      nxt(); nxt();
      rstn = 1'b1;
   endtask

   initial begin
      // reset state
      do_reset();
      rstn = 1'b0;
      @(negedge clk);
      chk("rst_valid", valid_out_a, 8'h00);
      chk("rst_payload", payload_out_a, 64'h0);
      chk("rst_last", last_out_a, 8'h00);
      chk("rst_ready_in", ready_in_a, 1'b0);
      nxt(); rstn = 1'b1;
      // 1: 3-beat packet to port 5
      drv(1, 8'h11, 0, 3'd5); @(negedge clk);
      chk("t1_rdy0", ready_in_a, 1'b1);
      chk("t1_v0", valid_out_a, 8'h00);
      nxt(); drv(1, 8'h12, 0, 3'd5); @(negedge clk);
      chk("t1_v1", valid_out_a, 8'h20);
      chk("t1_p1", payload_out_a[40 +: 8], 8'h11);
      chk("t1_l1", last_out_a, 8'h00);
      chk("t1_rdy1", ready_in_a, 1'b1);
      nxt(); drv(1, 8'h13, 1, 3'd5); @(negedge clk);
      chk("t1_v2", valid_out_a, 8'h20);
      chk("t1_p2", payload_out_a[40 +: 8], 8'h12);
      chk("t1_rdy2", ready_in_a, 1'b1);
      nxt(); drv(0, 8'h00, 0, 3'd0); @(negedge clk);
      chk("t1_v3", valid_out_a, 8'h20);
      chk("t1_p3", payload_out_a[40 +: 8], 8'h13);
      chk("t1_l3", last_out_a, 8'h20);
      nxt(); @(negedge clk);
      chk("t1_v4", valid_out_a, 8'h00);
      // 2: packet A to port 2 held by backpressure, packet B to port 6 behind it
      nxt(); ready_out = 8'hFB; drv(1, 8'hA0, 0, 3'd2);
      nxt(); drv(1, 8'hA1, 1, 3'd2); @(negedge clk);
      chk("t2_v1", valid_out_a, 8'h04);
      chk("t2_p1", payload_out_a[16 +: 8], 8'hA0);
      chk("t2_rdy1", ready_in_a, 1'b0);
      nxt(); @(negedge clk);
      chk("t2_v2", valid_out_a, 8'h04);
      chk("t2_rdy2", ready_in_a, 1'b0);
      nxt(); @(negedge clk);
      chk("t2_p3", payload_out_a[16 +: 8], 8'hA0);
      chk("t2_rdy3", ready_in_a, 1'b0);
      nxt(); ready_out = 8'hFF; @(negedge clk);
      chk("t2_v4", valid_out_a, 8'h04);
      chk("t2_rdy4", ready_in_a, 1'b1);
      nxt(); drv(1, 8'hB0, 0, 3'd6); @(negedge clk);
      chk("t2_p5", payload_out_a[16 +: 8], 8'hA1);
      chk("t2_l5", last_out_a, 8'h04);
      nxt(); drv(1, 8'hB1, 1, 3'd6); @(negedge clk);
      chk("t2_v6", valid_out_a, 8'h40);
      chk("t2_p6", payload_out_a[48 +: 8], 8'hB0);
      nxt(); drv(0, 8'h00, 0, 3'd0); @(negedge clk);
      chk("t2_v7", valid_out_a, 8'h40);
      chk("t2_p7", payload_out_a[48 +: 8], 8'hB1);
      chk("t2_l7", last_out_a, 8'h40);
      // 3: dest_in toggles mid-packet, route stays on port 5; next packet goes to port 1
      nxt(); drv(1, 8'h31, 0, 3'd5);
      for (int i = 0; i < 4; i++) begin
         nxt(); drv(1, 8'h32 + 8'(i), i == 3, 3'd1); @(negedge clk);
         chk("t3_v", valid_out_a, 8'h20);
         chk("t3_p", payload_out_a[40 +: 8], 8'h31 + 8'(i));
      end
      nxt(); drv(1, 8'h40, 1, 3'd1); @(negedge clk);
      chk("t3_vlast", valid_out_a, 8'h20);
      chk("t3_llast", last_out_a, 8'h20);
      nxt(); drv(0, 8'h00, 0, 3'd0); @(negedge clk);
      chk("t3_vnew", valid_out_a, 8'h02);
      chk("t3_pnew", payload_out_a[8 +: 8], 8'h40);
      // 5: reset mid-packet with stage full, dest re-sampled after
      nxt(); drv(1, 8'h50, 0, 3'd3);
      nxt(); drv(1, 8'h51, 0, 3'd3); rstn = 1'b0; @(negedge clk);
      chk("t5_vfull", valid_out_a, 8'h08);
      chk("t5_rdy_rst", ready_in_a, 1'b0);
      nxt(); rstn = 1'b1; drv(1, 8'h55, 1, 3'd4); @(negedge clk);
      chk("t5_vclr", valid_out_a, 8'h00);
      chk("t5_rdy", ready_in_a, 1'b1);
      nxt(); drv(0, 8'h00, 0, 3'd0); @(negedge clk);
      chk("t5_vnew", valid_out_a, 8'h10);
      chk("t5_pnew", payload_out_a[32 +: 8], 8'h55);
      chk("t5_lnew", last_out_a, 8'h10);
      // 4: per-beat routing, dest 0,7,3 without last
      nxt(); do_reset();
      drv(1, 8'h60, 0, 3'd0);
      nxt(); drv(1, 8'h61, 0, 3'd7); @(negedge clk);
      chk("t4_v0", valid_out_b, 8'h01);
      chk("t4_p0", payload_out_b[0 +: 8], 8'h60);
      nxt(); drv(1, 8'h62, 0, 3'd3); @(negedge clk);
      chk("t4_v7", valid_out_b, 8'h80);
      chk("t4_p7", payload_out_b[56 +: 8], 8'h61);
      nxt(); drv(0, 8'h00, 0, 3'd0); @(negedge clk);
      chk("t4_v3", valid_out_b, 8'h08);
      chk("t4_p3", payload_out_b[24 +: 8], 8'h62);
      chk("t4_l3", last_out_b, 8'h00);
      // 6: 6-port instance, in-range dest 5 then 4-beat packet to dest 7
      nxt(); do_reset();
      drv(1, 8'h70, 1, 3'd5);
      nxt(); drv(0, 8'h00, 0, 3'd0); @(negedge clk);
      chk("t6_v5", valid_out_c, 6'h20);
      chk("t6_p5", payload_out_c[40 +: 8], 8'h70);
      nxt();
      for (int i = 0; i < 4; i++) begin
         drv(1, 8'h80 + 8'(i), i == 3, 3'd7); @(negedge clk);
         chk("t6_rdy", ready_in_c, 1'b1);
`ifdef HS_PACKET_DEMUX_ERR_EN
         chk("t6_drop_v", valid_out_c, 6'h00);
         chk("t6_nopulse", ep_c, 1'b0);
`else
         if (i > 0) chk("t6_v0", valid_out_c, 6'h01);
`endif
         nxt();
      end
      drv(0, 8'h00, 0, 3'd0); @(negedge clk);
`ifdef HS_PACKET_DEMUX_ERR_EN
      chk("t6_drop_v4", valid_out_c, 6'h00);
      chk("t6_pulse", ep_c, 1'b1);
      chk("t6_cnt", ec_c, 8'd1);
      nxt(); @(negedge clk);
      chk("t6_pulse_end", ep_c, 1'b0);
      chk("t6_cnt_hold", ec_c, 8'd1);
`else
      chk("t6_v0_last", valid_out_c, 6'h01);
      chk("t6_p0_last", payload_out_c[0 +: 8], 8'h83);
      chk("t6_l0_last", last_out_c, 6'h01);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
